alsu_pipe: RTL and testbench

ALSU_PIPE -- requirements
Module: alsu_pipe

---
 rtl/alsu_pkg.sv | 17 +
 rtl/alsu_seq_mul.sv | 56 +++++
 rtl/alsu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alsu_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared state and opcode definitions for the ALSU pipeline
package alsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

endpackage

// File: rtl/alsu_seq_mul.sv
// rtl/alsu_seq_mul.sv - unsigned shift-add multiplier, one partial product per cycle
module alsu_seq_mul #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  // Load operands on start, then add one shifted multiplicand per cycle until
  // the counter empties; the done cycle itself drops busy on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CNT_INIT;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_ONE;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = r_acc;

endmodule

// File: rtl/alsu_pipe.sv
// rtl/alsu_pipe.sv - handshaked ALSU: logic, add, multiply, shift/rotate with held result
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter     PRIORITY   = "A",
  parameter     FULL_ADDER = "ON"
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               cin,
  input  logic               serial,
  input  logic               direction,
  input  logic               op_A,
  input  logic               op_B,
  input  logic               bypass_A,
  input  logic               bypass_B,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               err,
  output logic [15:0]        leds
);

  localparam int W2      = 2 * WIDTH;
  localparam bit PRI_B   = (PRIORITY == "B");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  state_t          r_state;
  state_t          w_state_next;
  logic            r_init;
  logic [W2-1:0]   r_out;
  logic            r_err;
  logic [W2-1:0]   r_sr;

  logic            w_accept;
  logic            w_is_mul;
  logic [WIDTH-1:0] w_pri;
  logic            w_cin;
  logic [W2-1:0]   w_result;
  logic            w_err;
  logic [W2-1:0]   w_sr_next;
  logic            w_sr_we;
  logic            w_mul_done;
  logic [W2-1:0]   w_product;

  // r_init keeps in_ready low until the first edge after reset releases.
  assign in_ready  = ((r_state == IDLE) && !r_init) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = !bypass_A && !bypass_B && (opcode == OP_MUL);
  assign w_pri     = PRI_B ? B : A;
  assign w_cin     = USE_CIN & cin;

  // Single-cycle result and shift-register update for the presented request.
  always_comb begin
    w_result  = '0;
    w_err     = 1'b0;
    w_sr_next = r_sr;
    w_sr_we   = 1'b0;
    if (bypass_A && bypass_B) begin
      w_result = {{WIDTH{1'b0}}, w_pri};
    end else if (bypass_A) begin
      w_result = {{WIDTH{1'b0}}, A};
    end else if (bypass_B) begin
      w_result = {{WIDTH{1'b0}}, B};
    end else begin
      case (opcode)
        OP_AND: begin
          if (op_A && op_B)  w_result = {{(W2-1){1'b0}}, &w_pri};
          else if (op_A)     w_result = {{(W2-1){1'b0}}, &A};
          else if (op_B)     w_result = {{(W2-1){1'b0}}, &B};
          else               w_result = {{WIDTH{1'b0}}, A & B};
        end
        OP_XOR: begin
          if (op_A && op_B)  w_result = {{(W2-1){1'b0}}, ^w_pri};
          else if (op_A)     w_result = {{(W2-1){1'b0}}, ^A};
          else if (op_B)     w_result = {{(W2-1){1'b0}}, ^B};
          else               w_result = {{WIDTH{1'b0}}, A ^ B};
        end
        OP_ADD: begin
          w_result = {{WIDTH{1'b0}}, A} + {{WIDTH{1'b0}}, B} + {{(W2-1){1'b0}}, w_cin};
        end
        OP_MUL: begin
          w_result = '0;
        end
        OP_SHIFT: begin
          w_sr_we   = 1'b1;
          w_sr_next = direction ? {r_sr[W2-2:0], serial} : {serial, r_sr[W2-1:1]};
          w_result  = w_sr_next;
        end
        OP_ROT: begin
          w_sr_we   = 1'b1;
          w_sr_next = direction ? {r_sr[W2-2:0], r_sr[W2-1]} : {r_sr[0], r_sr[W2-1:1]};
          w_result  = w_sr_next;
        end
        default: begin
          w_err = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state: multiply detours through BUSY, everything else lands in DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = w_is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (w_mul_done) w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) w_state_next = w_is_mul ? BUSY : DONE;
          else          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result, error flag and shift register; the held result only changes on
  // acceptance, multiply completion, or error clear when the consumer drains.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_init <= 1'b1;
      r_out  <= '0;
      r_err  <= 1'b0;
      r_sr   <= '0;
    end else begin
      r_init <= 1'b0;
      if (w_accept) begin
        r_out <= w_is_mul ? '0 : w_result;
        r_err <= w_is_mul ? 1'b0 : w_err;
        if (w_sr_we) r_sr <= w_sr_next;
      end else if ((r_state == BUSY) && w_mul_done) begin
        r_out <= w_product;
      end else if ((r_state == DONE) && out_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  alsu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rstn),
    .i_start  (w_accept && w_is_mul),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  assign out  = r_out;
  assign err  = r_err;
  assign leds = r_err ? 16'hFFFF : 16'h0000;

endmodule

// File: tb/tb_alsu_pipe.sv
// tb/tb_alsu_pipe.sv - directed self-checking bench for alsu_pipe
module tb_alsu_pipe;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [2:0] A;
  logic [2:0] B;
  logic       cin;
  logic       serial;
  logic       direction;
  logic       op_A;
  logic       op_B;
  logic       bypass_A;
  logic       bypass_B;
  logic [2:0] opcode;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, err_a;
  logic [5:0] out_a;
  logic [15:0] leds_a;
  logic       in_ready_b, out_valid_b, err_b;
  logic [5:0] out_b;
  logic [15:0] leds_b;

  int n_pass;
  int n_total;

  alsu_pipe u_dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a),
    .A(A), .B(B), .cin(cin), .serial(serial), .direction(direction),
    .op_A(op_A), .op_B(op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .opcode(opcode), .out_valid(out_valid_a), .out_ready(out_ready),
    .out(out_a), .err(err_a), .leds(leds_a)
  );

  alsu_pipe #(.PRIORITY("B")) u_dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b),
    .A(A), .B(B), .cin(cin), .serial(serial), .direction(direction),
    .op_A(op_A), .op_B(op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .opcode(opcode), .out_valid(out_valid_b), .out_ready(out_ready),
    .out(out_b), .err(err_b), .leds(leds_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] a, input logic [2:0] b, input logic c,
                         input logic ser, input logic dir, input logic opa, input logic opb,
                         input logic bpa, input logic bpb, input logic [2:0] opc);
    A = a; B = b; cin = c; serial = ser; direction = dir;
    op_A = opa; op_B = opb; bypass_A = bpa; bypass_B = bpb; opcode = opc;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #2 rstn = 1'b1;
    #1;
    n_total++; if (in_ready_a !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready_a); else n_pass++;
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid_a); else n_pass++;
    n_total++; if (out_a !== 6'd0) $display("FAIL reset_out got %0d want 0", out_a); else n_pass++;
    n_total++; if (err_a !== 1'b0 || leds_a !== 16'h0000) $display("FAIL reset_err_leds got %b/%h want 0/0000", err_a, leds_a); else n_pass++;
    @(negedge clk);
    rstn = 1'b0;
    tick;
    n_total++; if (in_ready_a !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready_a); else n_pass++;
  endtask

  task automatic test_add;
    set_req(3'd5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    n_total++; if (out_valid_a !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid_a); else n_pass++;
    n_total++; if (out_a !== 6'd9) $display("FAIL add_out got %0d want 9", out_a); else n_pass++;
    n_total++; if (in_ready_a !== 1'b0) $display("FAIL add_hold_ready got %b want 0", in_ready_a); else n_pass++;
    set_req(3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    tick;
    n_total++; if (out_a !== 6'd9) $display("FAIL add_stable got %0d want 9", out_a); else n_pass++;
    out_ready = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n_total++; if (out_a !== 6'd15) $display("FAIL add_carry got %0d want 15", out_a); else n_pass++;
    tick;
    out_ready = 1'b0;
    n_total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) $display("FAIL add_drain got valid=%b ready=%b want 0/1", out_valid_a, in_ready_a); else n_pass++;
  endtask

  task automatic test_mul;
    int  lat;
    bit  seen_ready;
    lat = 0; seen_ready = 0;
    set_req(3'd7, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    n_total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) $display("FAIL mul_busy got valid=%b ready=%b want 0/0", out_valid_a, in_ready_a); else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (out_valid_a === 1'b1) begin
        lat = i;
        break;
      end
      if (in_ready_a !== 1'b0) seen_ready = 1;
    end
    n_total++; if (lat != 4) $display("FAIL mul_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (out_a !== 6'd42) $display("FAIL mul_out got %0d want 42", out_a); else n_pass++;
    n_total++; if (seen_ready) $display("FAIL mul_ready_in_busy got 1 want 0"); else n_pass++;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [2:0] a;
    logic [2:0] b;
    logic       opa;
    logic       opb;
    logic       bpa;
    logic       bpb;
    logic [5:0] ea;
    logic [5:0] eb;
  } vec_t;

  task automatic test_logic_bypass;
    vec_t tbl[11];
    tbl[0]  = '{3'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 6'd1};
    tbl[1]  = '{3'd0, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    tbl[2]  = '{3'd0, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 6'd2};
    tbl[3]  = '{3'd0, 3'd7, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, 6'd0};
    tbl[4]  = '{3'd1, 3'd0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0};
    tbl[5]  = '{3'd1, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 6'd1};
    tbl[6]  = '{3'd1, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6, 6'd6};
    tbl[7]  = '{3'd1, 3'd7, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, 6'd0};
    tbl[8]  = '{3'd6, 3'd2, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 6'd2, 6'd5};
    tbl[9]  = '{3'd3, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 6'd5};
    tbl[10] = '{3'd4, 3'd4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 6'd4};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_req(tbl[i].a, tbl[i].b, 1'b0, 1'b0, 1'b0, tbl[i].opa, tbl[i].opb, tbl[i].bpa, tbl[i].bpb, tbl[i].opc);
      tick;
      n_total++;
      if (out_valid_a !== 1'b1 || out_a !== tbl[i].ea || out_b !== tbl[i].eb || err_a !== 1'b0)
        $display("FAIL logic_vec%0d got valid=%b outA=%0d outB=%0d err=%b want 1/%0d/%0d/0",
                 i, out_valid_a, out_a, out_b, err_a, tbl[i].ea, tbl[i].eb);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_shift_rotate;
    logic [2:0] t_opc[6];
    logic       t_dir[6];
    logic       t_bpa[6];
    logic [5:0] t_exp[6];
    t_opc = '{3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5};
    t_dir = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t_bpa = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t_exp = '{6'b000001, 6'b000011, 6'b000111, 6'b100011, 6'd3, 6'b000111};
    pulse_reset;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(3'd3, 3'd0, 1'b0, 1'b1, t_dir[i], 1'b0, 1'b0, t_bpa[i], 1'b0, t_opc[i]);
      tick;
      n_total++;
      if (out_valid_a !== 1'b1 || out_a !== t_exp[i])
        $display("FAIL shift_step%0d got valid=%b out=%b want 1/%b", i, out_valid_a, out_a, t_exp[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_err_hold;
    set_req(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6);
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (out_valid_a !== 1'b1 || out_a !== 6'd0 || err_a !== 1'b1 || leds_a !== 16'hFFFF)
        $display("FAIL err_hold%0d got valid=%b out=%0d err=%b leds=%h want 1/0/1/ffff",
                 i, out_valid_a, out_a, err_a, leds_a);
      else n_pass++;
      if (i < 4) tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    n_total++;
    if (err_a !== 1'b0 || leds_a !== 16'h0000 || out_valid_a !== 1'b0)
      $display("FAIL err_clear got err=%b leds=%h valid=%b want 0/0000/0", err_a, leds_a, out_valid_a);
    else n_pass++;
  endtask

  task automatic test_reset_in_busy;
    bit seen_valid;
    seen_valid = 0;
    set_req(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    #2 rstn = 1'b1;
    #1;
    n_total++;
    if (out_valid_a !== 1'b0 || out_a !== 6'd0 || in_ready_a !== 1'b0)
      $display("FAIL busy_reset got valid=%b out=%0d ready=%b want 0/0/0", out_valid_a, out_a, in_ready_a);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b0;
    tick;
    n_total++; if (in_ready_a !== 1'b1) $display("FAIL busy_release_ready got %b want 1", in_ready_a); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_a !== 1'b0) seen_valid = 1;
      tick;
    end
    n_total++; if (seen_valid) $display("FAIL busy_no_result got 1 want 0"); else n_pass++;
    out_ready = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset;
    test_add;
    test_mul;
    test_logic_bypass;
    test_shift_rotate;
    test_err_hold;
    test_reset_in_busy;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule
